// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - CPU-wide fetch constants, IF/ID record type and next-PC select encoding
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;  // sll $0,$0,0
  localparam int unsigned IMEM_WORDS = 1024;
  localparam logic [31:0] IMEM_LO    = 32'h0000_0000;
  localparam logic [31:0] IMEM_HI    = IMEM_LO + 32'(IMEM_WORDS * 4) - 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_HOLD   = 2'd1,
    NPC_BRANCH = 2'd2,
    NPC_JUMP   = 2'd3
  } npc_sel_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - pipeline register {instr, pc4, valid} with flush > hold > load
import fetch_stage_pkg::*;

module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  if_id_t stage_q;
  if_id_t stage_d;

  always_comb begin
    stage_d = stage_q;
    if (flush_i) begin
      stage_d.instr = NOP_INSTR;
      stage_d.pc4   = 32'h0;
      stage_d.valid = 1'b0;
    end else if (load_i) begin
      stage_d.instr = instr_i;
      stage_d.pc4   = pc4_i;
      stage_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q.instr <= NOP_INSTR;
      stage_q.pc4   <= 32'h0;
      stage_q.valid <= 1'b0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign instr_o = stage_q.instr;
  assign pc4_o   = stage_q.pc4;
  assign valid_o = stage_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC register, next-PC select, misaligned-target fault, IF/ID register
import fetch_stage_pkg::*;

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = fetch_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  input  logic [31:0] instr_in,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        fetch_fault
);

  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;
  npc_sel_e    npc_sel;

  assign pc_plus4 = pc_q + 32'd4;  // modulo 2^32: 0xFFFF_FFFC wraps to 0
  assign redirect = branch_taken | jump;

  always_comb begin
    npc_sel = NPC_SEQ;
    if (branch_taken)   npc_sel = NPC_BRANCH;
    else if (jump)      npc_sel = NPC_JUMP;
    else if (stall)     npc_sel = NPC_HOLD;
  end

  always_comb begin
    target  = 32'h0;
    pc_d    = pc_plus4;
    fault_d = 1'b0;
    unique case (npc_sel)
      NPC_BRANCH: target = branch_target;
      NPC_JUMP:   target = jump_target;
      default:    target = 32'h0;
    endcase
    unique case (npc_sel)
      NPC_BRANCH, NPC_JUMP: begin
        pc_d    = word_align(target);
        fault_d = |target[1:0];
      end
      NPC_HOLD: pc_d = pc_q;
      default:  pc_d = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  // The instruction returned for pc_q is squashed by a redirect, held by a stall.
  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect),
    .load_i  (!stall),
    .instr_i (instr_in),
    .pc4_i   (pc_plus4),
    .instr_o (if_id_instr),
    .pc4_o   (if_id_pc4),
    .valid_o (if_id_valid)
  );

  assign pc          = pc_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with directed vectors
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, instr_in, if_id_instr, if_id_pc4;
  logic        if_id_valid, fetch_fault;

  logic [31:0] imem [64];

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  assign instr_in = imem[pc[7:2]];

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc            (pc),
    .instr_in      (instr_in),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .fetch_fault   (fetch_fault)
  );

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, req);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.nm, "pc",    pc,                 e.pc);
      chk(e.nm, "instr", if_id_instr,        e.instr);
      chk(e.nm, "pc4",   if_id_pc4,          e.pc4);
      chk(e.nm, "valid", {31'b0, if_id_valid}, {31'b0, e.valid});
      chk(e.nm, "fault", {31'b0, fetch_fault}, {31'b0, e.fault});
    end
  end

  task automatic push(input string nm, input logic [31:0] epc, input logic [31:0] ei,
                      input logic [31:0] ep4, input logic ev, input logic ef);
    exp_t e;
    e.nm = nm; e.pc = epc; e.instr = ei; e.pc4 = ep4; e.valid = ev; e.fault = ef;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input string nm, input logic bt, input logic [31:0] bta,
                     input logic j, input logic [31:0] jta, input logic st,
                     input logic [31:0] epc, input logic [31:0] ei,
                     input logic [31:0] ep4, input logic ev, input logic ef);
    branch_taken = bt; branch_target = bta; jump = j; jump_target = jta; stall = st;
    @(posedge clk);
    #1;
    push(nm, epc, ei, ep4, ev, ef);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h2008_0001 + i * 32'h0001_0001;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;

    @(posedge clk); #1;
    push("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b1;

    cyc("free1",  0, 0, 0, 0, 0, 32'h4,  32'h2008_0001, 32'h4,  1, 0);
    cyc("free2",  0, 0, 0, 0, 0, 32'h8,  32'h2009_0002, 32'h8,  1, 0);
    for (int k = 0; k < 3; k++)
      cyc("stall",  0, 0, 0, 0, 1, 32'h8,  32'h2009_0002, 32'h8,  1, 0);
    cyc("resume", 0, 0, 0, 0, 0, 32'hC,  32'h200A_0003, 32'hC,  1, 0);
    cyc("br",     1, 32'h40, 0, 0, 0, 32'h40, 32'h0, 32'h0, 0, 0);
    cyc("br_tgt", 0, 0, 0, 0, 0, 32'h44, 32'h2018_0011, 32'h44, 1, 0);
    cyc("br_nxt", 0, 0, 0, 0, 0, 32'h48, 32'h2019_0012, 32'h48, 1, 0);
    cyc("br_jmp_st", 1, 32'h40, 1, 32'h80, 1, 32'h40, 32'h0, 32'h0, 0, 0);
    cyc("after4", 0, 0, 0, 0, 0, 32'h44, 32'h2018_0011, 32'h44, 1, 0);
    cyc("jmp_mis", 0, 0, 1, 32'h83, 0, 32'h80, 32'h0, 32'h0, 0, 1);
    cyc("jmp_tgt", 0, 0, 0, 0, 0, 32'h84, 32'h2028_0021, 32'h84, 1, 0);
    cyc("br_mis_win", 1, 32'h42, 1, 32'h80, 0, 32'h40, 32'h0, 32'h0, 0, 1);
    cyc("after_mis", 0, 0, 0, 0, 0, 32'h44, 32'h2018_0011, 32'h44, 1, 0);
    cyc("jmp_hi", 0, 0, 1, 32'hFFFF_FFF8, 0, 32'hFFFF_FFF8, 32'h0, 32'h0, 0, 0);
    cyc("hi1",    0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h2046_003F, 32'hFFFF_FFFC, 1, 0);
    cyc("wrap",   0, 0, 0, 0, 0, 32'h0,  32'h2047_0040, 32'h0,  1, 0);
    cyc("post_wrap", 0, 0, 0, 0, 0, 32'h4, 32'h2008_0001, 32'h4, 1, 0);

    branch_taken = 1'b0; jump = 1'b0; stall = 1'b1;
    @(posedge clk); #2;
    branch_taken = 1'b1; branch_target = 32'h40;
    rst_n = 1'b0;
    push("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    push("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk); #2;
    branch_taken = 1'b0; stall = 1'b0;
    rst_n = 1'b1;
    cyc("restart", 0, 0, 0, 0, 0, 32'h4, 32'h2008_0001, 32'h4, 1, 0);
    cyc("restart2", 0, 0, 0, 0, 0, 32'h8, 32'h2009_0002, 32'h8, 1, 0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
